// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot and periodic modes, pause via enable,
// and a one-cycle done pulse on terminal count.
module countdown_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             restart,
  input  logic             enable,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             running,
  output logic             expired
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_done;

  // Priority chain: reset > load > restart > enabled countdown in RUN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load) begin
        r_count  <= data;
        r_reload <= data;
        r_state  <= (data != '0) ? S_RUN : S_IDLE;
      end else if (restart) begin
        if (r_reload != '0) begin
          r_count <= r_reload;
          r_state <= S_RUN;
        end else begin
          r_count <= '0;
          r_state <= S_IDLE;
        end
      end else if (r_state == S_RUN && enable) begin
        if (r_count > WIDTH'(1)) begin
          r_count <= r_count - WIDTH'(1);
        end else begin
          // Terminal cycle: count is 1 here since RUN never holds 0.
          r_done <= 1'b1;
          if (auto_reload) begin
            r_count <= r_reload;
          end else begin
            r_count <= '0;
            r_state <= S_EXPIRED;
          end
        end
      end else if (r_state != S_RUN && r_state != S_EXPIRED && r_state != S_IDLE) begin
        r_state <= S_IDLE;
      end
    end
  end

  assign count   = r_count;
  assign done    = r_done;
  assign running = (r_state == S_RUN);
  assign expired = (r_state == S_EXPIRED);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed-vector bench for countdown_timer: table of per-cycle stimulus and
// expected outputs, plus hand sequences for periodic and mid-run reset cases.
module tb_countdown_timer;

  logic       clk;
  logic       reset;
  logic       load;
  logic       restart;
  logic       enable;
  logic       auto_reload;
  logic [7:0] data;
  logic [7:0] count;
  logic       done;
  logic       running;
  logic       expired;

  int n_checks = 0;
  int n_fail   = 0;

  countdown_timer #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .restart     (restart),
    .enable      (enable),
    .auto_reload (auto_reload),
    .data        (data),
    .count       (count),
    .done        (done),
    .running     (running),
    .expired     (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       ld;
    logic       rs;
    logic       en;
    logic       ar;
    logic [7:0] d;
    logic [7:0] exp_count;
    logic       exp_done;
    logic       exp_run;
    logic       exp_exp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string nm, logic rn, logic ld, logic rs, logic en,
                              logic ar, logic [7:0] d, logic [7:0] c,
                              logic dn, logic ru, logic ex);
    vec_t v;
    v.name = nm; v.rst_n = rn; v.ld = ld; v.rs = rs; v.en = en; v.ar = ar;
    v.d = d; v.exp_count = c; v.exp_done = dn; v.exp_run = ru; v.exp_exp = ex;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic apply(vec_t v);
    @(negedge clk);
    reset = v.rst_n; load = v.ld; restart = v.rs; enable = v.en;
    auto_reload = v.ar; data = v.d;
    @(posedge clk);
    #1;
    chk({v.name, ".count"},   32'(count),   32'(v.exp_count));
    chk({v.name, ".done"},    32'(done),    32'(v.exp_done));
    chk({v.name, ".running"}, 32'(running), 32'(v.exp_run));
    chk({v.name, ".expired"}, 32'(expired), 32'(v.exp_exp));
  endtask

  initial begin
    int done_cnt;
    int last_done;
    int gap_ok;

    reset = 1'b1; load = 1'b0; restart = 1'b0; enable = 1'b0;
    auto_reload = 1'b0; data = 8'd0;

    //                  name         rst ld rs en ar data  cnt dn ru ex
    vq.push_back(mk("reset",        0, 1, 1, 1, 1, 8'd7,   0, 0, 0, 0));
    vq.push_back(mk("idle_en",      1, 0, 0, 1, 1, 8'd7,   0, 0, 0, 0));
    vq.push_back(mk("idle_en2",     1, 0, 0, 1, 0, 8'd0,   0, 0, 0, 0));
    // single shot
    vq.push_back(mk("ss_load",      1, 1, 0, 1, 0, 8'd3,   3, 0, 1, 0));
    vq.push_back(mk("ss_2",         1, 0, 0, 1, 0, 8'd0,   2, 0, 1, 0));
    vq.push_back(mk("ss_1",         1, 0, 0, 1, 0, 8'd0,   1, 0, 1, 0));
    vq.push_back(mk("ss_term",      1, 0, 0, 1, 0, 8'd0,   0, 1, 0, 1));
    vq.push_back(mk("ss_hold",      1, 0, 0, 1, 0, 8'd0,   0, 0, 0, 1));
    vq.push_back(mk("ss_hold2",     1, 0, 0, 1, 1, 8'd0,   0, 0, 0, 1));
    // pause and restart
    vq.push_back(mk("pr_load",      1, 1, 0, 0, 0, 8'd5,   5, 0, 1, 0));
    vq.push_back(mk("pr_4",         1, 0, 0, 1, 0, 8'd0,   4, 0, 1, 0));
    vq.push_back(mk("pr_3",         1, 0, 0, 1, 0, 8'd0,   3, 0, 1, 0));
    vq.push_back(mk("pr_pause1",    1, 0, 0, 0, 0, 8'd0,   3, 0, 1, 0));
    vq.push_back(mk("pr_pause2",    1, 0, 0, 0, 0, 8'd0,   3, 0, 1, 0));
    vq.push_back(mk("pr_pause3",    1, 0, 0, 0, 0, 8'd0,   3, 0, 1, 0));
    vq.push_back(mk("pr_restart",   1, 0, 1, 1, 0, 8'd0,   5, 0, 1, 0));
    // load collides with terminal count
    vq.push_back(mk("col_load",     1, 1, 0, 1, 0, 8'd3,   3, 0, 1, 0));
    vq.push_back(mk("col_2",        1, 0, 0, 1, 0, 8'd0,   2, 0, 1, 0));
    vq.push_back(mk("col_1",        1, 0, 0, 1, 0, 8'd0,   1, 0, 1, 0));
    vq.push_back(mk("col_ld9",      1, 1, 0, 1, 0, 8'd9,   9, 0, 1, 0));
    vq.push_back(mk("col_ld0",      1, 1, 0, 1, 0, 8'd0,   0, 0, 0, 0));
    vq.push_back(mk("col_rs_zero",  1, 0, 1, 1, 0, 8'd0,   0, 0, 0, 0));
    // restart collides with terminal count
    vq.push_back(mk("rc_load",      1, 1, 0, 0, 0, 8'd2,   2, 0, 1, 0));
    vq.push_back(mk("rc_1",         1, 0, 0, 1, 0, 8'd0,   1, 0, 1, 0));
    vq.push_back(mk("rc_restart",   1, 0, 1, 1, 0, 8'd0,   2, 0, 1, 0));
    // auto_reload only matters at the terminal cycle
    vq.push_back(mk("ar_load",      1, 1, 0, 0, 1, 8'd3,   3, 0, 1, 0));
    vq.push_back(mk("ar_2",         1, 0, 0, 1, 1, 8'd0,   2, 0, 1, 0));
    vq.push_back(mk("ar_1",         1, 0, 0, 1, 0, 8'd0,   1, 0, 1, 0));
    vq.push_back(mk("ar_reload",    1, 0, 0, 1, 1, 8'd0,   3, 1, 1, 0));
    vq.push_back(mk("ar_b2",        1, 0, 0, 1, 1, 8'd0,   2, 0, 1, 0));
    vq.push_back(mk("ar_b1",        1, 0, 0, 1, 1, 8'd0,   1, 0, 1, 0));
    vq.push_back(mk("ar_expire",    1, 0, 0, 1, 0, 8'd0,   0, 1, 0, 1));
    vq.push_back(mk("ar_exp_rs",    1, 0, 1, 0, 0, 8'd0,   3, 0, 1, 0));
    // reload == 1 periodic: done every cycle
    vq.push_back(mk("one_load",     1, 1, 0, 1, 1, 8'd1,   1, 0, 1, 0));
    vq.push_back(mk("one_a",        1, 0, 0, 1, 1, 8'd0,   1, 1, 1, 0));
    vq.push_back(mk("one_b",        1, 0, 0, 1, 1, 8'd0,   1, 1, 1, 0));
    vq.push_back(mk("one_c",        1, 0, 0, 1, 1, 8'd0,   1, 1, 1, 0));
    vq.push_back(mk("one_pause",    1, 0, 0, 0, 1, 8'd0,   1, 0, 1, 0));
    // reset on the terminal edge suppresses done
    vq.push_back(mk("rt_load",      1, 1, 0, 0, 0, 8'd1,   1, 0, 1, 0));
    vq.push_back(mk("rt_reset",     0, 0, 0, 1, 0, 8'd0,   0, 0, 0, 0));

    foreach (vq[i]) apply(vq[i]);

    // Periodic mode: 12 enabled cycles after loading 4.
    apply(mk("per_load", 1, 1, 0, 1, 1, 8'd4, 4, 0, 1, 0));
    done_cnt = 0; last_done = -1; gap_ok = 1;
    for (int k = 1; k <= 12; k++) begin
      apply(mk("per_run", 1, 0, 0, 1, 1, 8'd0,
               (k % 4 == 0) ? 8'd4 : 8'(4 - (k % 4)), (k % 4 == 0), 1, 0));
      if (done === 1'b1) begin
        if (last_done >= 0 && k - last_done != 4) gap_ok = 0;
        last_done = k;
        done_cnt++;
      end
    end
    chk("per_done_count", 32'(done_cnt), 32'd3);
    chk("per_done_gap",   32'(gap_ok),   32'd1);

    // Reset in the middle of a long count, with load asserted alongside.
    apply(mk("rm_load", 1, 1, 0, 0, 0, 8'd200, 200, 0, 1, 0));
    for (int k = 1; k <= 10; k++)
      apply(mk("rm_run", 1, 0, 0, 1, 0, 8'd0, 8'(200 - k), 0, 1, 0));
    apply(mk("rm_reset",   0, 1, 0, 1, 0, 8'd55, 0, 0, 0, 0));
    apply(mk("rm_restart", 1, 0, 1, 1, 0, 8'd0,  0, 0, 0, 0));
    apply(mk("rm_idle",    1, 0, 0, 1, 1, 8'd0,  0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
